// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/sub dispatch slice.
//   disp_state_t : sequencer states of the request dispatcher
//   FP_QNAN      : quiet NaN returned when an operation is aborted
// The request record itself depends on the caller's tag width, so it is
// declared inside the instantiating module, next to its TAG_W parameter.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_HOLD
    } disp_state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fadd_sub_req_fifo.sv
// Synchronous request FIFO for the add/sub dispatcher.
//   clk, rst   : clock, asynchronous active-low reset
//   push, data : write one entry when not full (a push while full is dropped)
//   pop, head  : head is the oldest entry; pop removes it when not empty
//   full, empty: occupancy flags derived from the entry count
// A push and a pop in the same cycle leave the count unchanged.
module fadd_sub_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately left without reset; an entry is
    // only ever read while the count says it was written, and leaving it out of
    // the reset network lets it map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fadd_sub_dispatch.sv
// Request queue and sequencer in front of the floating-point add/sub core.
//   clk, rst                    : clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake (ready = FIFO not full)
//   req_sub, req_a, req_b       : operation (1 = a-b) and IEEE-754 operands
//   req_tag                     : caller tag returned with the result
//   fa_start                    : one-cycle start pulse to the core
//   fa_subtract, fa_a, fa_b     : operation/operands, stable for the whole op
//   fa_busy, fa_done            : core status (done is a level)
//   fa_z, fa_ovf, fa_unf        : core result and flags
//   res_valid/res_ready         : result handshake
//   res_z, res_ovf, res_unf     : captured result, or qNaN on timeout
//   res_err                     : set when the core did not finish in time
//   res_tag                     : tag of the request that produced the result
module fadd_sub_dispatch
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sub,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             fa_start,
    output logic             fa_subtract,
    output logic [31:0]      fa_a,
    output logic [31:0]      fa_b,
    input  logic             fa_busy,
    input  logic             fa_done,
    input  logic [31:0]      fa_z,
    input  logic             fa_ovf,
    input  logic             fa_unf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_z,
    output logic             res_ovf,
    output logic             res_unf,
    output logic             res_err,
    output logic [TAG_W-1:0] res_tag
);

    typedef struct packed {
        logic             sub;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    localparam int unsigned    CW      = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    req_t             push_req;
    req_t             head_req;
    logic             fifo_full;
    logic             fifo_empty;

    disp_state_t      state_q;
    disp_state_t      state_d;
    logic             pop;
    logic             capture;
    logic             abort;
    logic             consume;
    logic             timeout_hit;
    logic [CW-1:0]    to_cnt;
    logic [TAG_W-1:0] op_tag;

    assign push_req  = '{sub: req_sub, a: req_a, b: req_b, tag: req_tag};
    assign req_ready = !fifo_full;

    fadd_sub_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .data  (push_req),
        .pop   (pop),
        .head  (head_req),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign timeout_hit = (to_cnt == TO_LAST);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        consume = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_ARM;
            ST_ARM: begin
                // A done level still high from the previous operation is
                // ignored until the core shows it has really started.
                if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = ST_HOLD;
                end else if (fa_busy && !fa_done) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Done is tested first so a completion on the timeout cycle
                // is still delivered as a good result.
                if (fa_done) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_valid && res_ready) begin
                    consume = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Cleared while the start pulse is out, counting while waiting on the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state_q == ST_ISSUE) begin
            to_cnt <= '0;
        end else if ((state_q == ST_ARM) || (state_q == ST_WAIT)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Operands load only on a pop, so they stay put from ISSUE through HOLD.
    // fa_start follows the pop by one edge, i.e. it is high exactly in ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fa_start    <= 1'b0;
            fa_subtract <= 1'b0;
            fa_a        <= '0;
            fa_b        <= '0;
            op_tag      <= '0;
        end else begin
            fa_start <= pop;
            if (pop) begin
                fa_subtract <= head_req.sub;
                fa_a        <= head_req.a;
                fa_b        <= head_req.b;
                op_tag      <= head_req.tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_z     <= '0;
            res_ovf   <= 1'b0;
            res_unf   <= 1'b0;
            res_err   <= 1'b0;
            res_tag   <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_z     <= fa_z;
            res_ovf   <= fa_ovf;
            res_unf   <= fa_unf;
            res_err   <= 1'b0;
            res_tag   <= op_tag;
        end else if (abort) begin
            res_valid <= 1'b1;
            res_z     <= FP_QNAN;
            res_ovf   <= 1'b0;
            res_unf   <= 1'b0;
            res_err   <= 1'b1;
            res_tag   <= op_tag;
        end else if (consume) begin
            res_valid <= 1'b0;
        end
    end

endmodule
